// File: rtl/vram_write_bridge.sv
// CPU-to-VRAM write bridge: decodes bus writes into region/offset, buffers them
// in an in-order FIFO and retires them whenever the PPU leaves the head region idle.
module vram_write_bridge #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] STATUS_ADDR = 32'h0640_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  input  logic [3:0]  ppu_busy,
  output logic [3:0]  vram_we,
  output logic [13:0] vram_addr,
  output logic [31:0] vram_wdata,
  output logic        err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          dec_err_q, dec_err_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   mem_dout_q, mem_dout_d;
  logic          err_q, err_d;

  logic [47:0]   fifo_mem [FIFO_DEPTH];

  logic [19:0]   region_lim;
  logic          dec_valid, is_status;
  logic          bus_wr, bus_rd;
  logic          wr_accept, status_clr, dec_fail, ovf_evt;
  logic          fifo_empty, fifo_full, push, pop;
  logic [47:0]   head;
  logic [1:0]    head_region;
  logic [31:0]   status_word;

  always_comb begin
    case (mem_addr[21:20])
      2'd0:    region_lim = 20'd1024;
      2'd1:    region_lim = 20'd2048;
      2'd2:    region_lim = 20'd16384;
      default: region_lim = 20'd256;
    endcase
  end

  // Only regions 0..3 of the 0x06xx_xxxx window exist; the status register sits outside them.
  assign dec_valid  = (mem_addr[31:24] == 8'h06) && (mem_addr[23:22] == 2'b00)
                      && (mem_addr[19:0] < region_lim);
  assign is_status  = (mem_addr == STATUS_ADDR);
  assign bus_wr     = mem_en && mem_we;
  assign bus_rd     = mem_en && !mem_we;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign wr_accept  = bus_wr && dec_valid;
  assign status_clr = bus_wr && is_status && mem_din[0];
  assign dec_fail   = bus_wr && !dec_valid && !is_status;
  assign push       = wr_accept && (!fifo_full || pop);
  assign ovf_evt    = wr_accept && !push;

  assign head        = fifo_mem[rd_ptr_q];
  assign head_region = head[47:46];

  for (genvar gi = 0; gi < 4; gi++) begin : g_we
    assign vram_we[gi] = !fifo_empty && (head_region == 2'(gi)) && !ppu_busy[gi];
  end

  assign pop        = |vram_we;
  assign vram_addr  = fifo_empty ? 14'd0 : head[45:32];
  assign vram_wdata = fifo_empty ? 32'd0 : head[31:0];

  assign status_word = {drop_cnt_q, 5'd0, dec_err_q, ovf_q, 9'(count_q)};

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (!push && pop) count_d = count_q - 1'b1;

    // A fresh event in the same cycle as a clear leaves the flag set.
    ovf_d      = ovf_evt ? 1'b1 : (status_clr ? 1'b0 : ovf_q);
    dec_err_d  = dec_fail ? 1'b1 : (status_clr ? 1'b0 : dec_err_q);
    drop_cnt_d = drop_cnt_q;
    if (ovf_evt) begin
      if (status_clr)                  drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (status_clr) begin
      drop_cnt_d = 16'd0;
    end
    err_d      = ovf_d || dec_err_d;

    mem_dout_d = mem_dout_q;
    if (bus_rd) mem_dout_d = is_status ? status_word : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      dec_err_q  <= 1'b0;
      drop_cnt_q <= 16'd0;
      mem_dout_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      dec_err_q  <= dec_err_d;
      drop_cnt_q <= drop_cnt_d;
      mem_dout_q <= mem_dout_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_q] <= {mem_addr[21:20], mem_addr[13:0], mem_din};
  end

  assign mem_dout = mem_dout_q;
  assign err      = err_q;

endmodule
